// File: rtl/rotation_kick_resolver_if.sv
// Shared tetromino types and the request/result bundle between the
// rotation stage, the kick resolver and the game FSM.
package global_pkg;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_J = 3'd3,
        PIECE_L = 3'd4,
        PIECE_S = 3'd5,
        PIECE_Z = 3'd6
    } piece_t;

    // data[r][c]: 4x4 bounding box, a cell is solid when nonzero
    typedef struct packed {
        piece_t                 shape;
        logic [3:0][3:0][2:0]   data;
    } tetromino_t;

    typedef struct packed {
        logic signed [5:0] x;
        logic signed [5:0] y;
    } coord_t;

    typedef struct packed {
        tetromino_t  tetromino;
        coord_t      coordinate;
        logic [1:0]  rotation;
    } tetromino_ctrl;

endpackage

interface rotation_kick_resolver_if #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
);
    import global_pkg::*;

    logic                          start;
    tetromino_ctrl                 t_in;
    logic [1:0]                    from_rotation;
    logic [BOARD_W*BOARD_H-1:0]    board_occupied;
    logic                          busy;
    logic                          done;
    logic                          success;
    logic [2:0]                    kick_idx;
    tetromino_ctrl                 t_out;

    modport master (
        output start, t_in, from_rotation, board_occupied,
        input  busy, done, success, kick_idx, t_out
    );

    modport slave (
        input  start, t_in, from_rotation, board_occupied,
        output busy, done, success, kick_idx, t_out
    );

endinterface

// File: rtl/rotation_kick_resolver.sv
// Tries the SRS wall-kick offsets for a rotated tetromino against a latched
// copy of the playfield, one offset per cycle, and reports the first
// collision-free placement (or failure) to the game FSM.
//
// state  | meaning
// IDLE   | waiting for start; request, board and rotation are latched on start
// CHECK  | testing kick k against the latched board
// REPORT | result registered; done pulses on the way back to IDLE
module rotation_kick_resolver
    import global_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    rotation_kick_resolver_if.slave  bus
);

    localparam int NCELL = BOARD_W * BOARD_H;
    localparam int IW    = $clog2(NCELL);
    localparam logic signed [7:0] W_S = 8'(BOARD_W);
    localparam logic signed [7:0] H_S = 8'(BOARD_H);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REPORT} state_t;

    // screen-space offset: dy already points down
    typedef struct packed {
        logic signed [3:0] dx;
        logic signed [3:0] dy;
    } kick_t;

    state_t              state_q, state_d;
    logic [2:0]          k_q, k_d;
    tetromino_ctrl       t_q, t_d;
    logic [1:0]          from_q, from_d;
    logic [NCELL-1:0]    board_q, board_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                success_q, success_d;
    logic [2:0]          kick_idx_q, kick_idx_d;
    tetromino_ctrl       t_out_q, t_out_d;

    kick_t               kick;
    logic                clear;
    logic                single_test;
    logic [2:0]          last_k;
    logic signed [7:0]   xs, ys, dxs, dys, bx, by;
    logic [IW-1:0]       idx;

    // Base tables in y-up form: A = JLSTZ into R, C = JLSTZ into L,
    // E = I 0->R / L->2, F = I R->2 / 0->L. The reverse transitions are the
    // same rows negated, which the neg flag selects. Transitions that are not
    // a quarter turn never get past test 0, whose entry is (0,0) everywhere.
    function automatic kick_t kick_lookup(input piece_t p, input logic [1:0] from,
                                          input logic [1:0] to, input logic [2:0] k);
        logic signed [3:0] tx, ty;
        logic [1:0]        sel;
        logic              neg;
        kick_t             res;
        tx  = 4'sd0;
        ty  = 4'sd0;
        sel = 2'd0;
        neg = 1'b0;
        if (p == PIECE_I) begin
            case ({from, to})
                4'b00_01: begin sel = 2'd2; neg = 1'b0; end
                4'b11_10: begin sel = 2'd2; neg = 1'b0; end
                4'b01_00: begin sel = 2'd2; neg = 1'b1; end
                4'b10_11: begin sel = 2'd2; neg = 1'b1; end
                4'b01_10: begin sel = 2'd3; neg = 1'b0; end
                4'b00_11: begin sel = 2'd3; neg = 1'b0; end
                4'b10_01: begin sel = 2'd3; neg = 1'b1; end
                4'b11_00: begin sel = 2'd3; neg = 1'b1; end
                default:  begin sel = 2'd0; neg = 1'b0; end
            endcase
        end else begin
            case ({from, to})
                4'b00_01, 4'b10_01: begin sel = 2'd0; neg = 1'b0; end
                4'b01_00, 4'b01_10: begin sel = 2'd0; neg = 1'b1; end
                4'b00_11, 4'b10_11: begin sel = 2'd1; neg = 1'b0; end
                4'b11_00, 4'b11_10: begin sel = 2'd1; neg = 1'b1; end
                default:            begin sel = 2'd0; neg = 1'b0; end
            endcase
        end
        case (sel)
            2'd0: case (k)
                3'd1:    begin tx = -4'sd1; ty =  4'sd0; end
                3'd2:    begin tx = -4'sd1; ty =  4'sd1; end
                3'd3:    begin tx =  4'sd0; ty = -4'sd2; end
                3'd4:    begin tx = -4'sd1; ty = -4'sd2; end
                default: begin tx =  4'sd0; ty =  4'sd0; end
            endcase
            2'd1: case (k)
                3'd1:    begin tx =  4'sd1; ty =  4'sd0; end
                3'd2:    begin tx =  4'sd1; ty =  4'sd1; end
                3'd3:    begin tx =  4'sd0; ty = -4'sd2; end
                3'd4:    begin tx =  4'sd1; ty = -4'sd2; end
                default: begin tx =  4'sd0; ty =  4'sd0; end
            endcase
            2'd2: case (k)
                3'd1:    begin tx = -4'sd2; ty =  4'sd0; end
                3'd2:    begin tx =  4'sd1; ty =  4'sd0; end
                3'd3:    begin tx = -4'sd2; ty = -4'sd1; end
                3'd4:    begin tx =  4'sd1; ty =  4'sd2; end
                default: begin tx =  4'sd0; ty =  4'sd0; end
            endcase
            default: case (k)
                3'd1:    begin tx = -4'sd1; ty =  4'sd0; end
                3'd2:    begin tx =  4'sd2; ty =  4'sd0; end
                3'd3:    begin tx = -4'sd1; ty =  4'sd2; end
                3'd4:    begin tx =  4'sd2; ty = -4'sd1; end
                default: begin tx =  4'sd0; ty =  4'sd0; end
            endcase
        endcase
        // flip y to screen orientation (y grows downward)
        res.dx = neg ? -tx : tx;
        res.dy = neg ? ty : -ty;
        return res;
    endfunction

    // Collision test of the latched piece at the current kick offset
    always_comb begin
        kick  = kick_lookup(t_q.tetromino.shape, from_q, t_q.rotation, k_q);
        clear = 1'b1;
        xs    = {{2{t_q.coordinate.x[5]}}, t_q.coordinate.x};
        ys    = {{2{t_q.coordinate.y[5]}}, t_q.coordinate.y};
        dxs   = {{4{kick.dx[3]}}, kick.dx};
        dys   = {{4{kick.dy[3]}}, kick.dy};
        bx    = '0;
        by    = '0;
        idx   = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                bx = xs + 8'(c) + dxs;
                by = ys + 8'(r) + dys;
                if (t_q.tetromino.data[r][c] != 3'd0) begin
                    if (bx[7] || by[7] || bx >= W_S || by >= H_S) begin
                        clear = 1'b0;
                    end else begin
                        idx = IW'(int'(by) * BOARD_W + int'(bx));
                        if (board_q[idx]) begin
                            clear = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // O pieces, no-op rotations and half turns only ever try offset (0,0)
    always_comb begin
        single_test = (t_q.tetromino.shape == PIECE_O) ||
                      (from_q == t_q.rotation) ||
                      ((from_q ^ t_q.rotation) == 2'b10);
        last_k = single_test ? 3'd0 : 3'd4;
    end

    // Next-state and result logic
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        t_d        = t_q;
        from_d     = from_q;
        board_d    = board_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        success_d  = success_q;
        kick_idx_d = kick_idx_q;
        t_out_d    = t_out_q;
        case (state_q)
            S_IDLE: begin
                // a start coinciding with the done pulse is not a new request
                if (bus.start && !done_q) begin
                    t_d     = bus.t_in;
                    from_d  = bus.from_rotation;
                    board_d = bus.board_occupied;
                    k_d     = 3'd0;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (clear) begin
                    t_out_d              = t_q;
                    t_out_d.coordinate.x = t_q.coordinate.x + {{2{kick.dx[3]}}, kick.dx};
                    t_out_d.coordinate.y = t_q.coordinate.y + {{2{kick.dy[3]}}, kick.dy};
                    success_d            = 1'b1;
                    kick_idx_d           = k_q;
                    state_d              = S_REPORT;
                end else if (k_q == last_k) begin
                    t_out_d    = t_q;
                    success_d  = 1'b0;
                    kick_idx_d = k_q;
                    state_d    = S_REPORT;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_REPORT: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            t_q        <= '0;
            from_q     <= '0;
            board_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            success_q  <= 1'b0;
            kick_idx_q <= '0;
            t_out_q    <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            t_q        <= t_d;
            from_q     <= from_d;
            board_q    <= board_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            success_q  <= success_d;
            kick_idx_q <= kick_idx_d;
            t_out_q    <= t_out_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.success  = success_q;
    assign bus.kick_idx = kick_idx_q;
    assign bus.t_out    = t_out_q;

endmodule

// File: tb/tb_rotation_kick_resolver.sv
// Bench for rotation_kick_resolver: directed vector table, hand-written
// abort/ignore sequences, and randomized requests checked against a
// reference model that walks the literal SRS kick tables.
module tb_rotation_kick_resolver;
    import global_pkg::*;

    localparam int BW = 10;
    localparam int BH = 20;
    localparam int NC = BW * BH;

    logic clk;
    logic rst;

    rotation_kick_resolver_if #(.BOARD_W(BW), .BOARD_H(BH)) bus ();

    rotation_kick_resolver #(.BOARD_W(BW), .BOARD_H(BH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // y-up SRS tables keyed by from*4+to
    int jx[16][5], jy[16][5], ix[16][5], iy[16][5];

    task automatic init_tables();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 5; j++) begin
                jx[i][j] = 0; jy[i][j] = 0; ix[i][j] = 0; iy[i][j] = 0;
            end
        jx[1]  = '{0,-1,-1, 0,-1}; jy[1]  = '{0, 0, 1,-2,-2};
        jx[4]  = '{0, 1, 1, 0, 1}; jy[4]  = '{0, 0,-1, 2, 2};
        jx[6]  = '{0, 1, 1, 0, 1}; jy[6]  = '{0, 0,-1, 2, 2};
        jx[9]  = '{0,-1,-1, 0,-1}; jy[9]  = '{0, 0, 1,-2,-2};
        jx[11] = '{0, 1, 1, 0, 1}; jy[11] = '{0, 0, 1,-2,-2};
        jx[14] = '{0,-1,-1, 0,-1}; jy[14] = '{0, 0,-1, 2, 2};
        jx[12] = '{0,-1,-1, 0,-1}; jy[12] = '{0, 0,-1, 2, 2};
        jx[3]  = '{0, 1, 1, 0, 1}; jy[3]  = '{0, 0, 1,-2,-2};
        ix[1]  = '{0,-2, 1,-2, 1}; iy[1]  = '{0, 0, 0,-1, 2};
        ix[4]  = '{0, 2,-1, 2,-1}; iy[4]  = '{0, 0, 0, 1,-2};
        ix[6]  = '{0,-1, 2,-1, 2}; iy[6]  = '{0, 0, 0, 2,-1};
        ix[9]  = '{0, 1,-2, 1,-2}; iy[9]  = '{0, 0, 0,-2, 1};
        ix[11] = '{0, 2,-1, 2,-1}; iy[11] = '{0, 0, 0, 1,-2};
        ix[14] = '{0,-2, 1,-2, 1}; iy[14] = '{0, 0, 0,-1, 2};
        ix[12] = '{0, 1,-2, 1,-2}; iy[12] = '{0, 0, 0,-2, 1};
        ix[3]  = '{0,-1, 2,-1, 2}; iy[3]  = '{0, 0, 0, 2,-1};
    endtask

    function automatic tetromino_ctrl mk(input piece_t p, input logic [15:0] m,
                                         input logic [1:0] rot, input int x, input int y);
        tetromino_ctrl t;
        t = '0;
        t.tetromino.shape = p;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (m[r*4+c]) t.tetromino.data[r][c] = 3'(int'(p) + 1);
        t.rotation     = rot;
        t.coordinate.x = 6'(x);
        t.coordinate.y = 6'(y);
        return t;
    endfunction

    function automatic bit fits(input tetromino_ctrl t, input int dx, input int dy,
                                input logic [NC-1:0] b);
        int x, y;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (t.tetromino.data[r][c] != 3'd0) begin
                    x = int'($signed(t.coordinate.x)) + c + dx;
                    y = int'($signed(t.coordinate.y)) + r + dy;
                    if (x < 0 || x >= BW || y < 0 || y >= BH) return 1'b0;
                    if (b[y*BW + x]) return 1'b0;
                end
        return 1'b1;
    endfunction

    function automatic void model(input tetromino_ctrl t, input logic [1:0] from,
                                  input logic [NC-1:0] b, output logic s,
                                  output logic [2:0] k, output tetromino_ctrl o);
        int key, turn, n, dx, dy;
        key  = 4*int'(from) + int'(t.rotation);
        turn = (int'(t.rotation) - int'(from) + 4) % 4;
        n    = (t.tetromino.shape == PIECE_O || (turn != 1 && turn != 3)) ? 1 : 5;
        s = 1'b0;
        k = 3'(n - 1);
        o = t;
        for (int i = 0; i < n; i++) begin
            dx = (t.tetromino.shape == PIECE_I) ? ix[key][i] : jx[key][i];
            dy = (t.tetromino.shape == PIECE_I) ? -iy[key][i] : -jy[key][i];
            if (fits(t, dx, dy, b)) begin
                s = 1'b1;
                k = 3'(i);
                o.coordinate.x = t.coordinate.x + 6'(dx);
                o.coordinate.y = t.coordinate.y + 6'(dy);
                return;
            end
        end
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request: start sampled at edge N, latency counted in edges after N.
    // The board input is scrambled right after start to show it was latched.
    task automatic run_case(input string tag, input tetromino_ctrl t, input logic [1:0] from,
                            input logic [NC-1:0] b, input logic es, input logic [2:0] ek,
                            input tetromino_ctrl eo, input int elat);
        int  cyc;
        bit  got;
        @(negedge clk);
        bus.t_in           = t;
        bus.from_rotation  = from;
        bus.board_occupied = b;
        bus.start          = 1'b1;
        @(posedge clk);
        #1;
        bus.start          = 1'b0;
        bus.board_occupied = ~b;
        check({tag, " busy"}, 128'(bus.busy), 128'(1));
        cyc = 0;
        got = 1'b0;
        while (cyc < 12 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) got = 1'b1;
        end
        check({tag, " latency"}, 128'(cyc), 128'(elat));
        check({tag, " success"}, 128'(bus.success), 128'(es));
        check({tag, " kick_idx"}, 128'(bus.kick_idx), 128'(ek));
        check({tag, " t_out"}, 128'(bus.t_out), 128'(eo));
        check({tag, " busy_at_done"}, 128'(bus.busy), 128'(0));
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, 128'(bus.done), 128'(0));
    endtask

    typedef struct {
        string      name;
        piece_t     p;
        logic [15:0] m;
        logic [1:0] rot;
        logic [1:0] from;
        int         x, y;
        bit         full;
        int         occ;
        logic       es;
        logic [2:0] ek;
        int         ex, ey;
        int         elat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [NC-1:0] b, full_b;
        tetromino_ctrl t, eo, t5;
        logic          ms;
        logic [2:0]    mk_k;
        int            ndone, lat;
        logic          cap_s;
        logic [2:0]    cap_k;
        tetromino_ctrl cap_t;
        int            dens;

        init_tables();
        full_b = '1;

        //            name     piece   mask     rot from  x   y full occ  s  k   ex  ey lat
        vecs[0] = '{"v_empty", PIECE_T, 16'h0262, 2'd1, 2'd0,  3,  0, 0, -1, 1, 0,  3,  0, 2};
        vecs[1] = '{"v_kick1", PIECE_T, 16'h0262, 2'd1, 2'd0,  3,  5, 0, 65, 1, 1,  2,  5, 3};
        vecs[2] = '{"v_full",  PIECE_T, 16'h0262, 2'd1, 2'd0,  3,  0, 1, -1, 0, 4,  3,  0, 6};
        vecs[3] = '{"v_o",     PIECE_O, 16'h0066, 2'd1, 2'd0,  4,  0, 0,  5, 0, 0,  4,  0, 2};
        vecs[4] = '{"v_i_wall",PIECE_I, 16'h4444, 2'd1, 2'd0, -3,  0, 0, -1, 1, 2, -2,  0, 4};
        vecs[5] = '{"v_floor", PIECE_T, 16'h0262, 2'd1, 2'd0,  3, 18, 0, -1, 1, 2,  2, 17, 4};
        vecs[6] = '{"v_norot", PIECE_T, 16'h0262, 2'd1, 2'd1,  3,  0, 1, -1, 0, 0,  3,  0, 2};
        vecs[7] = '{"v_nocell",PIECE_T, 16'h0000, 2'd1, 2'd0,  3,  0, 1, -1, 1, 0,  3,  0, 2};
        vecs[8] = '{"v_l_r2",  PIECE_L, 16'h0170, 2'd2, 2'd1, -1,  5, 0, -1, 1, 1,  0,  5, 3};

        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.t_in           = '0;
        bus.from_rotation  = '0;
        bus.board_occupied = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 128'(bus.busy), 128'(0));
        check("reset done", 128'(bus.done), 128'(0));
        check("reset success", 128'(bus.success), 128'(0));
        check("reset kick_idx", 128'(bus.kick_idx), 128'(0));
        check("reset t_out", 128'(bus.t_out), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            t = mk(vecs[i].p, vecs[i].m, vecs[i].rot, vecs[i].x, vecs[i].y);
            b = vecs[i].full ? full_b : '0;
            if (vecs[i].occ >= 0) b[vecs[i].occ] = 1'b1;
            eo = t;
            eo.coordinate.x = 6'(vecs[i].ex);
            eo.coordinate.y = 6'(vecs[i].ey);
            run_case(vecs[i].name, t, vecs[i].from, b, vecs[i].es, vecs[i].ek, eo, vecs[i].elat);
        end

        // start while busy plus a board change: only the latched search reports
        t5 = mk(PIECE_T, 16'h0262, 2'd1, 3, 0);
        @(negedge clk);
        bus.t_in = t5; bus.from_rotation = 2'd0; bus.board_occupied = full_b; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0; lat = 0; cap_s = 1'b1; cap_k = '0; cap_t = '0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                bus.start          = 1'b1;
                bus.t_in           = mk(PIECE_J, 16'h0007, 2'd1, 0, 0);
                bus.board_occupied = '0;
            end else if (i == 3) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                ndone++;
                lat   = i;
                cap_s = bus.success;
                cap_k = bus.kick_idx;
                cap_t = bus.t_out;
            end
        end
        check("busy_start done_count", 128'(ndone), 128'(1));
        check("busy_start latency", 128'(lat), 128'(6));
        check("busy_start success", 128'(cap_s), 128'(0));
        check("busy_start kick_idx", 128'(cap_k), 128'(4));
        check("busy_start t_out", 128'(cap_t), 128'(t5));

        // reset during CHECK at k=3 aborts without a done pulse
        t = mk(PIECE_T, 16'h0262, 2'd1, 3, 0);
        run_case("pre_reset", t, 2'd0, '0, 1'b1, 3'd0, t, 2);
        @(negedge clk);
        bus.t_in = t; bus.from_rotation = 2'd0; bus.board_occupied = full_b; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy", 128'(bus.busy), 128'(0));
        check("abort done", 128'(bus.done), 128'(0));
        check("abort success", 128'(bus.success), 128'(0));
        check("abort kick_idx", 128'(bus.kick_idx), 128'(0));
        check("abort t_out", 128'(bus.t_out), 128'(0));
        rst = 1'b0;
        ndone = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("abort no_done", 128'(ndone), 128'(0));
        run_case("post_reset", t, 2'd0, '0, 1'b1, 3'd0, t, 2);

        // randomized requests against the reference model
        for (int n = 0; n < 80; n++) begin
            t = mk(piece_t'(3'($urandom_range(6))), 16'($urandom) & 16'($urandom),
                   2'($urandom_range(3)), $urandom_range(12) - 3, $urandom_range(22) - 2);
            dens = $urandom_range(60, 5);
            for (int c = 0; c < NC; c++) b[c] = ($urandom_range(99) < dens);
            model(t, 2'($urandom_range(3)), b, ms, mk_k, eo);
            // model() was called with a random from; recompute with a fixed one to drive
            begin
                logic [1:0] fr;
                fr = 2'($urandom_range(3));
                model(t, fr, b, ms, mk_k, eo);
                run_case($sformatf("rand%0d", n), t, fr, b, ms, mk_k, eo, int'(mk_k) + 2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
